// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the RISC datapath: IF/ID/EX/MEM/WB/HALT sequencing with
// outputs decoded from the registered state and the live instruction fields.
module multicycle_controller (
    input  logic       clk,
    input  logic       Rst,
    input  logic [4:0] opcode,
    input  logic [1:0] ALUopcode,
    input  logic [2:0] PSW_NZC,
    output logic       ALUorNot,
    output logic       LIorMOV,
    output logic       MEMresource,
    output logic       WE_MEM,
    output logic       Buff_MEMIns,
    output logic       WBresource,
    output logic       RBresource,
    output logic       oprandB,
    output logic       LI,
    output logic       PCplus1orWB,
    output logic       WE_RF,
    output logic       Flag,
    output logic       ALUop,
    output logic       Buff_PSW,
    output logic       Branch,
    output logic [1:0] Jump,
    output logic       Buff_PC,
    output logic       done,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic is_hlt, is_alurr, is_mov, is_addi, is_subi, is_lli, is_lhi;
    logic is_ldrri, is_ldr, is_strri, is_str, is_long, br_taken;
    logic flag_z, flag_c, unused_flag_n;

    assign flag_z        = PSW_NZC[1];
    assign flag_c        = PSW_NZC[0];
    assign unused_flag_n = PSW_NZC[2];

    assign is_hlt   = (opcode == 5'b00000) && (ALUopcode == 2'b01);
    assign is_alurr = (opcode == 5'b00001);
    assign is_mov   = (opcode == 5'b00010);
    assign is_addi  = (opcode == 5'b00011);
    assign is_subi  = (opcode == 5'b00100);
    assign is_lli   = (opcode == 5'b01000);
    assign is_lhi   = (opcode == 5'b01001);
    assign is_ldrri = (opcode == 5'b01010);
    assign is_ldr   = is_ldrri || (opcode == 5'b01011);
    assign is_strri = (opcode == 5'b01100);
    assign is_str   = is_strri || (opcode == 5'b01101);
    // Everything not in the multi-stage classes (OutR, NOP, branches, HLT, unmapped) retires in ID.
    assign is_long  = is_alurr || is_mov || is_addi || is_subi || is_lli || is_lhi || is_ldr || is_str;

    always_comb begin
        unique case (opcode)
            5'b10000: br_taken = ~flag_c;
            5'b10001: br_taken = flag_c;
            5'b10010: br_taken = ~flag_z;
            5'b10011: br_taken = flag_z;
            5'b10100: br_taken = 1'b1;
            default:  br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = S_IF;
        ALUorNot    = 1'b0;
        LIorMOV     = 1'b0;
        MEMresource = 1'b0;
        WE_MEM      = 1'b0;
        Buff_MEMIns = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        oprandB     = 1'b0;
        LI          = 1'b0;
        PCplus1orWB = 1'b0;
        WE_RF       = 1'b0;
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Buff_PSW    = 1'b0;
        Branch      = 1'b0;
        Buff_PC     = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IF: begin
                Buff_MEMIns = 1'b1;
                state_d     = S_ID;
            end
            S_ID: begin
                if (!is_long) begin
                    Buff_PC = 1'b1;
                    Branch  = br_taken;
                    state_d = is_hlt ? S_HALT : S_IF;
                end else begin
                    oprandB    = is_addi || is_subi || is_ldrri || is_strri;
                    RBresource = is_lhi;
                    LI         = is_lhi;
                    state_d    = S_EX;
                end
            end
            S_EX: begin
                // For register-register ops ALUopcode already encodes {sub, carry}.
                if (is_alurr || is_addi || is_subi) begin
                    Buff_PSW = 1'b1;
                    Flag     = is_alurr && ALUopcode[0];
                    ALUop    = (is_alurr && ALUopcode[1]) || is_subi;
                end
                RBresource = is_str;
                state_d    = S_MEM;
            end
            S_MEM: begin
                ALUorNot    = is_lli || is_lhi || is_mov;
                LIorMOV     = is_mov;
                MEMresource = is_ldr || is_str;
                WE_MEM      = is_str;
                Buff_PC     = is_str;
                state_d     = is_str ? S_IF : S_WB;
            end
            S_WB: begin
                WE_RF       = 1'b1;
                Buff_PC     = 1'b1;
                PCplus1orWB = !is_ldr;
                WBresource  = is_ldr;
                state_d     = S_IF;
            end
            S_HALT: begin
                done    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_IF;
        endcase
        // Forcing outputs low while reset is held also kills any in-flight write strobe at once.
        if (!Rst) begin
            ALUorNot    = 1'b0;
            LIorMOV     = 1'b0;
            MEMresource = 1'b0;
            WE_MEM      = 1'b0;
            Buff_MEMIns = 1'b0;
            WBresource  = 1'b0;
            RBresource  = 1'b0;
            oprandB     = 1'b0;
            LI          = 1'b0;
            PCplus1orWB = 1'b0;
            WE_RF       = 1'b0;
            Flag        = 1'b0;
            ALUop       = 1'b0;
            Buff_PSW    = 1'b0;
            Branch      = 1'b0;
            Buff_PC     = 1'b0;
            done        = 1'b0;
        end
    end

    assign Jump  = 2'b00;
    assign state = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a mnemonic-level
// reference model that lists the expected per-cycle state and control word.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic [4:0] opcode = 5'b0;
    logic [1:0] ALUopcode = 2'b10;
    logic [2:0] PSW_NZC = 3'b0;
    logic ALUorNot, LIorMOV, MEMresource, WE_MEM, Buff_MEMIns, WBresource, RBresource;
    logic oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW, Branch, Buff_PC, done;
    logic [1:0] Jump;
    logic [2:0] state;

    multicycle_controller dut (
        .clk(clk), .Rst(Rst), .opcode(opcode), .ALUopcode(ALUopcode), .PSW_NZC(PSW_NZC),
        .ALUorNot(ALUorNot), .LIorMOV(LIorMOV), .MEMresource(MEMresource), .WE_MEM(WE_MEM),
        .Buff_MEMIns(Buff_MEMIns), .WBresource(WBresource), .RBresource(RBresource),
        .oprandB(oprandB), .LI(LI), .PCplus1orWB(PCplus1orWB), .WE_RF(WE_RF), .Flag(Flag),
        .ALUop(ALUop), .Buff_PSW(Buff_PSW), .Branch(Branch), .Jump(Jump), .Buff_PC(Buff_PC),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    localparam int P_ALUORNOT = 18, P_LIORMOV = 17, P_MEMRES = 16, P_WEMEM = 15, P_MEMINS = 14;
    localparam int P_WBRES = 13, P_RBRES = 12, P_OPRANDB = 11, P_LI = 10, P_PC1WB = 9, P_WERF = 8;
    localparam int P_FLAG = 7, P_ALUOP = 6, P_PSW = 5, P_BRANCH = 4, P_BUFFPC = 1, P_DONE = 0;

    logic [18:0] dut_out;
    assign dut_out = {ALUorNot, LIorMOV, MEMresource, WE_MEM, Buff_MEMIns, WBresource, RBresource,
                      oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop, Buff_PSW, Branch, Jump,
                      Buff_PC, done};

    typedef enum {M_OUTR, M_HLT, M_NOP, M_ADD, M_ADC, M_SUB, M_SBB, M_MOV, M_ADDI, M_SUBI,
                  M_LLI, M_LHI, M_LDRRI, M_LDRRR, M_STRRI, M_STRRR,
                  M_BCC, M_BCS, M_BNE, M_BEQ, M_BAL} mn_t;

    int total = 0;
    int bad   = 0;
    logic [2:0]  exp_st[$];
    logic [18:0] exp_out[$];

    function automatic mn_t decode(input logic [4:0] op, input logic [1:0] alu);
        mn_t m;
        case (op)
            5'd0:  m = (alu == 2'd0) ? M_OUTR : (alu == 2'd1) ? M_HLT : M_NOP;
            5'd1:  m = (alu == 2'd0) ? M_ADD : (alu == 2'd1) ? M_ADC : (alu == 2'd2) ? M_SUB : M_SBB;
            5'd2:  m = M_MOV;
            5'd3:  m = M_ADDI;
            5'd4:  m = M_SUBI;
            5'd8:  m = M_LLI;
            5'd9:  m = M_LHI;
            5'd10: m = M_LDRRI;
            5'd11: m = M_LDRRR;
            5'd12: m = M_STRRI;
            5'd13: m = M_STRRR;
            5'd16: m = M_BCC;
            5'd17: m = M_BCS;
            5'd18: m = M_BNE;
            5'd19: m = M_BEQ;
            5'd20: m = M_BAL;
            default: m = M_NOP;
        endcase
        return m;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from IF to retirement.
    task automatic build_expected(input logic [4:0] op, input logic [1:0] alu, input logic [2:0] nzc);
        mn_t m = decode(op, alu);
        logic [18:0] o;
        bit is_load  = (m == M_LDRRI) || (m == M_LDRRR);
        bit is_store = (m == M_STRRI) || (m == M_STRRR);
        bit short_cls = (m inside {M_OUTR, M_HLT, M_NOP, M_BCC, M_BCS, M_BNE, M_BEQ, M_BAL});
        bit z = nzc[1];
        bit c = nzc[0];
        exp_st.delete();
        exp_out.delete();
        o = '0; o[P_MEMINS] = 1'b1;
        exp_st.push_back(3'd0); exp_out.push_back(o);
        o = '0;
        if (short_cls) begin
            o[P_BUFFPC] = 1'b1;
            case (m)
                M_BCC:   o[P_BRANCH] = !c;
                M_BCS:   o[P_BRANCH] = c;
                M_BNE:   o[P_BRANCH] = !z;
                M_BEQ:   o[P_BRANCH] = z;
                M_BAL:   o[P_BRANCH] = 1'b1;
                default: o[P_BRANCH] = 1'b0;
            endcase
            exp_st.push_back(3'd1); exp_out.push_back(o);
            return;
        end
        o[P_OPRANDB] = (m inside {M_ADDI, M_SUBI, M_LDRRI, M_STRRI});
        o[P_RBRES]   = (m == M_LHI);
        o[P_LI]      = (m == M_LHI);
        exp_st.push_back(3'd1); exp_out.push_back(o);
        o = '0;
        if (m inside {M_ADD, M_ADC, M_SUB, M_SBB, M_ADDI, M_SUBI}) begin
            o[P_PSW]   = 1'b1;
            o[P_FLAG]  = (m inside {M_ADC, M_SBB});
            o[P_ALUOP] = (m inside {M_SUB, M_SBB, M_SUBI});
        end
        o[P_RBRES] = is_store;
        exp_st.push_back(3'd2); exp_out.push_back(o);
        o = '0;
        o[P_ALUORNOT] = (m inside {M_LLI, M_LHI, M_MOV});
        o[P_LIORMOV]  = (m == M_MOV);
        o[P_MEMRES]   = is_load || is_store;
        o[P_WEMEM]    = is_store;
        o[P_BUFFPC]   = is_store;
        exp_st.push_back(3'd3); exp_out.push_back(o);
        if (is_store) return;
        o = '0;
        o[P_WERF]   = 1'b1;
        o[P_BUFFPC] = 1'b1;
        o[P_PC1WB]  = !is_load;
        o[P_WBRES]  = is_load;
        exp_st.push_back(3'd4); exp_out.push_back(o);
    endtask

    // Called at posedge+1 with the DUT in IF; returns at posedge+1 after the last cycle.
    task automatic run_instr(input logic [4:0] op, input logic [1:0] alu, input logic [2:0] nzc,
                             input string tag);
        int n;
        build_expected(op, alu, nzc);
        n = exp_st.size();
        opcode = op; ALUopcode = alu; PSW_NZC = nzc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if ({state, dut_out} !== {exp_st[i], exp_out[i]}) begin
                bad++;
                $display("FAIL %s cycle%0d: got state=%0d outs=%b, want state=%0d outs=%b",
                         tag, i, state, dut_out, exp_st[i], exp_out[i]);
            end
            @(posedge clk); #1;
        end
        $display("txn %s op=%b alu=%b nzc=%b cycles=%0d", tag, op, alu, nzc, n);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        Rst = 1'b0;
        #1;
        total++;
        if ({state, dut_out} !== 22'd0) begin
            bad++;
            $display("FAIL reset_async: got state=%0d outs=%b, want 0", state, dut_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({state, dut_out} !== 22'd0) begin
                bad++;
                $display("FAIL reset_hold%0d: got state=%0d outs=%b, want 0", i, state, dut_out);
            end
        end
        @(posedge clk); #1;
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        run_instr(5'b00000, 2'b10, 3'b000, "NOP_after_reset");
    endtask

    task automatic test_alu();
        run_instr(5'b00001, 2'b00, 3'b000, "ADD");
        run_instr(5'b00001, 2'b11, 3'b001, "SBB");
        run_instr(5'b00001, 2'b01, 3'b101, "ADC");
        run_instr(5'b00011, 2'b00, 3'b000, "ADDI");
        run_instr(5'b00100, 2'b10, 3'b000, "SUBI");
        run_instr(5'b00010, 2'b00, 3'b000, "MOV");
    endtask

    task automatic test_branches();
        run_instr(5'b10011, 2'b00, 3'b010, "BEQ_taken");
        run_instr(5'b10011, 2'b00, 3'b000, "BEQ_not");
        run_instr(5'b10100, 2'b00, 3'b000, "BAL_0");
        run_instr(5'b10100, 2'b00, 3'b111, "BAL_7");
        run_instr(5'b10000, 2'b00, 3'b001, "BCC_c1");
        run_instr(5'b10001, 2'b00, 3'b001, "BCS_c1");
        run_instr(5'b10010, 2'b00, 3'b000, "BNE_z0");
    endtask

    task automatic test_mem();
        run_instr(5'b01100, 2'b00, 3'b000, "STRri");
        run_instr(5'b01101, 2'b00, 3'b000, "STRrr");
        run_instr(5'b01010, 2'b00, 3'b000, "LDRri");
        run_instr(5'b01011, 2'b00, 3'b000, "LDRrr");
        run_instr(5'b01001, 2'b00, 3'b000, "LHI");
        run_instr(5'b01000, 2'b00, 3'b000, "LLI");
    endtask

    task automatic test_unmapped();
        run_instr(5'b11111, 2'b01, 3'b111, "UNMAPPED_11111");
        run_instr(5'b00000, 2'b00, 3'b000, "OUTR");
    endtask

    task automatic test_back_to_back();
        logic [4:0] tbl [0:16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10, 5'd11,
                                   5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd1};
        logic [4:0] op;
        logic [1:0] alu;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
            else                           op = tbl[$urandom_range(0, 16)];
            alu = 2'($urandom_range(0, 3));
            if (op == 5'd0 && alu == 2'd1) alu = 2'd3;
            run_instr(op, alu, 3'($urandom_range(0, 7)), "RAND");
        end
    endtask

    task automatic test_halt();
        run_instr(5'b00000, 2'b01, 3'($urandom_range(0, 7)), "HLT");
        for (int i = 0; i < 20; i++) begin
            opcode = 5'($urandom_range(0, 31));
            @(negedge clk);
            total++;
            if ({state, dut_out} !== {3'd5, 19'd1}) begin
                bad++;
                $display("FAIL halt_hold%0d: got state=%0d outs=%b, want state=5 outs=%b",
                         i, state, dut_out, 19'd1);
            end
        end
        do_reset();
        run_instr(5'b00001, 2'b10, 3'b000, "SUB_after_halt");
    endtask

    task automatic test_mid_reset();
        opcode = 5'b01101; ALUopcode = 2'b00; PSW_NZC = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({state, WE_MEM} !== {3'd3, 1'b1}) begin
            bad++;
            $display("FAIL midreset_pre: got state=%0d WE_MEM=%b, want state=3 WE_MEM=1", state, WE_MEM);
        end
        #1 Rst = 1'b0;
        #1;
        total++;
        if ({state, dut_out} !== 22'd0) begin
            bad++;
            $display("FAIL midreset_same_cycle: got state=%0d outs=%b, want 0", state, dut_out);
        end
        @(posedge clk); #1;
        total++;
        if ({state, dut_out} !== 22'd0) begin
            bad++;
            $display("FAIL midreset_next_cycle: got state=%0d outs=%b, want 0", state, dut_out);
        end
        Rst = 1'b1;
        run_instr(5'b00001, 2'b00, 3'b000, "ADD_after_midreset");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_branches();
        test_mem();
        test_unmapped();
        test_back_to_back();
        test_halt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
